// File: rtl/histogram_bin_arbiter_pkg.sv
// Shared definitions for the histogram bin arbiter: default widths,
// FSM state encoding and pipeline operation type.
// Optional feature macro: HIST_BIN_SATURATE_EN (see histogram_bin_arbiter.sv).
package histogram_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      UPD  = 2'd1,
      RD   = 2'd2
   } op_e;

endpackage

// File: rtl/histogram_bin_arbiter_if.sv
// Bundle of the host-side request/response signals and the bin RAM port.
// The slave modport is the arbiter's view; master is the host/RAM view.
// Optional feature macro: HIST_BIN_SATURATE_EN (no effect on this file).
interface histogram_bin_arbiter_if
   import histogram_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

   logic                  upd_valid;
   logic [ADDR_WIDTH-1:0] upd_bin;
   logic                  upd_ready;
   logic                  rd_valid;
   logic [ADDR_WIDTH-1:0] rd_bin;
   logic                  rd_ready;
   logic                  rd_data_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  clr_start;
   logic                  clr_busy;
   logic [ADDR_WIDTH-1:0] mem_raddr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_wen;

   modport slave (
      input  upd_valid, upd_bin, rd_valid, rd_bin, clr_start, mem_rdata,
      output upd_ready, rd_ready, rd_data_valid, rd_data, clr_busy,
             mem_raddr, mem_waddr, mem_wdata, mem_wen
   );

   modport master (
      output upd_valid, upd_bin, rd_valid, rd_bin, clr_start, mem_rdata,
      input  upd_ready, rd_ready, rd_data_valid, rd_data, clr_busy,
             mem_raddr, mem_waddr, mem_wdata, mem_wen
   );

endinterface

// File: rtl/histogram_bin_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter (read vs update). After reset the read
// side has priority; whichever side wins hands priority to the other.
// Optional feature macro: HIST_BIN_SATURATE_EN (no effect on this file).
module hist_rr_arb2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic rd_req_i,
   input  logic upd_req_i,
   output logic rd_ready_o,
   output logic upd_ready_o,
   output logic rd_gnt_o,
   output logic upd_gnt_o
);

   logic prio_upd_q;
   logic prio_upd_d;
   logic conflict;

   // Readiness only drops for the side that loses a simultaneous request,
   // so a lone requester is always accepted while enabled.
   always_comb begin
      conflict    = rd_req_i & upd_req_i;
      rd_ready_o  = en_i & ~(conflict & prio_upd_q);
      upd_ready_o = en_i & ~(conflict & ~prio_upd_q);
      rd_gnt_o    = rd_ready_o & rd_req_i;
      upd_gnt_o   = upd_ready_o & upd_req_i;
      prio_upd_d  = prio_upd_q;
      if (rd_gnt_o) begin
         prio_upd_d = 1'b1;
      end else if (upd_gnt_o) begin
         prio_upd_d = 1'b0;
      end
   end

   // Priority pointer: low means read is favoured on the next conflict.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_upd_q <= 1'b0;
      end else begin
         prio_upd_q <= prio_upd_d;
      end
   end

endmodule

// File: rtl/histogram_bin_arbiter.sv
// Histogram bin arbiter: accepts one increment or read per cycle into a
// two-stage RAM pipeline (S0 issues the read address, S1 completes the op),
// forwards the previous write on a same-bin hazard, and runs a bulk clear.
// Optional feature macro: HIST_BIN_SATURATE_EN -- when defined, incrementing
// a bin at its maximum value leaves it at the maximum instead of wrapping.
module histogram_bin_arbiter
   import histogram_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   histogram_bin_arbiter_if.slave  bus_io
);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic                  clr_busy_q;
   logic                  clr_done_q;

   op_e                   s1_op_q;
   logic [ADDR_WIDTH-1:0] s1_bin_q;

   logic                  fwd_valid_q;
   logic [ADDR_WIDTH-1:0] fwd_bin_q;
   logic [DATA_WIDTH-1:0] fwd_data_q;

   logic                  clr_accept;
   logic                  arb_en;
   logic                  rd_gnt;
   logic                  upd_gnt;
   logic                  rd_ready;
   logic                  upd_ready;
   op_e                   s0_op;
   logic [ADDR_WIDTH-1:0] s0_bin;
   logic [DATA_WIDTH-1:0] old_val;
   logic [DATA_WIDTH-1:0] upd_wdata;

   // A clear is only taken in RUN and only when no clear is still being
   // wound down; in that same cycle no host request may enter the pipeline.
   always_comb begin
      clr_accept = (state_q == RUN) & bus_io.clr_start & ~clr_busy_q;
      arb_en     = (state_q == RUN) & ~clr_accept;
   end

   hist_rr_arb2 u_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (arb_en),
      .rd_req_i    (bus_io.rd_valid),
      .upd_req_i   (bus_io.upd_valid),
      .rd_ready_o  (rd_ready),
      .upd_ready_o (upd_ready),
      .rd_gnt_o    (rd_gnt),
      .upd_gnt_o   (upd_gnt)
   );

   // Stage S0: the granted op presents its bin to the RAM read port now.
   always_comb begin
      s0_op  = NONE;
      s0_bin = '0;
      if (upd_gnt) begin
         s0_op  = UPD;
         s0_bin = bus_io.upd_bin;
      end else if (rd_gnt) begin
         s0_op  = RD;
         s0_bin = bus_io.rd_bin;
      end
   end

   // Stage S1: the RAM read is stale when the previous op wrote this bin in
   // the same cycle the read was issued, so take the forwarded value then.
   always_comb begin
      if (fwd_valid_q && (fwd_bin_q == s1_bin_q)) begin
         old_val = fwd_data_q;
      end else begin
         old_val = bus_io.mem_rdata;
      end
`ifdef HIST_BIN_SATURATE_EN
      if (old_val == {DATA_WIDTH{1'b1}}) begin
         upd_wdata = old_val;
      end else begin
         upd_wdata = old_val + 1'b1;
      end
`else
      upd_wdata = old_val + 1'b1;
`endif
   end

   // Output drive: clear writes take the write port in CLEAR, updates write
   // from S1, reads return data from S1; idle cycles drive zeros.
   always_comb begin
      bus_io.upd_ready     = upd_ready;
      bus_io.rd_ready      = rd_ready;
      bus_io.clr_busy      = clr_busy_q;
      bus_io.mem_raddr     = s0_bin;
      bus_io.mem_wen       = 1'b0;
      bus_io.mem_waddr     = '0;
      bus_io.mem_wdata     = '0;
      bus_io.rd_data_valid = 1'b0;
      bus_io.rd_data       = '0;
      if (state_q == CLEAR) begin
         bus_io.mem_wen   = 1'b1;
         bus_io.mem_waddr = clr_cnt_q;
      end else if (s1_op_q == UPD) begin
         bus_io.mem_wen   = 1'b1;
         bus_io.mem_waddr = s1_bin_q;
         bus_io.mem_wdata = upd_wdata;
      end else if (s1_op_q == RD) begin
         bus_io.rd_data_valid = 1'b1;
         bus_io.rd_data       = old_val;
      end
   end

   // Pipeline registers: S0 moves into S1, and every S1 update is
   // remembered for one cycle so the following op can forward from it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_op_q     <= NONE;
         s1_bin_q    <= '0;
         fwd_valid_q <= 1'b0;
         fwd_bin_q   <= '0;
         fwd_data_q  <= '0;
      end else begin
         s1_op_q     <= s0_op;
         s1_bin_q    <= s0_bin;
         fwd_valid_q <= (s1_op_q == UPD) && (state_q != CLEAR);
         fwd_bin_q   <= s1_bin_q;
         fwd_data_q  <= upd_wdata;
      end
   end

   // Control FSM: RUN serves requests, DRAIN gives the last S1 op a cycle to
   // retire, CLEAR zeroes every bin in ascending order. The busy flag stays
   // up for one extra cycle after the final zero write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RUN;
         clr_cnt_q  <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         clr_done_q <= 1'b0;
         if (clr_done_q) begin
            clr_busy_q <= 1'b0;
         end
         case (state_q)
            RUN: begin
               if (clr_accept) begin
                  state_q    <= DRAIN;
                  clr_busy_q <= 1'b1;
               end
            end
            DRAIN: begin
               state_q   <= CLEAR;
               clr_cnt_q <= '0;
            end
            CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                  state_q    <= RUN;
                  clr_done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_histogram_bin_arbiter.sv
// Directed bench for histogram_bin_arbiter with a behavioural bin RAM
// (one-cycle read latency, write not visible to a same-cycle read).
// Optional feature macro: HIST_BIN_SATURATE_EN selects the saturating
// expectation for the max-value increment vector.
module tb_histogram_bin_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;

   logic clk_i;
   logic rst_ni;

   int total;
   int bad;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          pre_wen;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   histogram_bin_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   histogram_bin_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus_io (bus.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Bin RAM model; the bench preload port shares the write port and is only
   // used while the pipeline is idle.
   always @(posedge clk_i) begin
      if (pre_wen) begin
         mem[pre_addr] <= pre_data;
      end else if (bus.mem_wen) begin
         mem[bus.mem_waddr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= mem[bus.mem_raddr];
   end

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic uv, input logic [AW-1:0] ub,
                                input logic rv, input logic [AW-1:0] rb,
                                input logic cs);
      bus.upd_valid = uv;
      bus.upd_bin   = ub;
      bus.rd_valid  = rv;
      bus.rd_bin    = rb;
      bus.clr_start = cs;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pre_wen  = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_wen  = 1'b0;
   endtask

   task automatic doReset();
      rst_ni = 1'b0;
      repeat (2) tick();
      rst_ni = 1'b1;
      tick();
   endtask

   // Bulk clear: counts busy cycles, zero writes and their order, and
   // injects a second clr_start mid-clear that must be ignored.
   task automatic runClear();
      int busyCycles;
      int writes;
      int orderErr;
      int rdyErr;
      int fell;
      logic [AW-1:0] expAddr;
      busyCycles = 0;
      writes     = 0;
      orderErr   = 0;
      rdyErr     = 0;
      fell       = 0;
      expAddr    = '0;
      applyStimulus(0, 0, 0, 0, 1);
      #1;
      checkOutput("clr_start_readies", {62'd0, bus.rd_ready, bus.upd_ready}, 64'd0);
      tick();
      for (int c = 0; c < 400; c++) begin
         applyStimulus(0, 0, 0, 0, (c == 10));
         #1;
         if (!bus.clr_busy) begin
            fell = 1;
            break;
         end
         busyCycles++;
         if (c == 0 && (bus.rd_ready || bus.upd_ready)) rdyErr++;
         if (bus.mem_wen) begin
            if (bus.mem_waddr !== expAddr || bus.mem_wdata !== '0) orderErr++;
            if (bus.rd_ready || bus.upd_ready) rdyErr++;
            writes++;
            expAddr++;
         end
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("clr_busy_fell", 64'(fell), 64'd1);
      checkOutput("clr_busy_cycles", 64'(busyCycles), 64'd258);
      checkOutput("clr_zero_writes", 64'(writes), 64'd256);
      checkOutput("clr_write_order", 64'(orderErr), 64'd0);
      checkOutput("clr_readies_low", 64'(rdyErr), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] satExp;
      total   = 0;
      bad     = 0;
      pre_wen = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      rst_ni  = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      checkOutput("rst_upd_ready", 64'(bus.upd_ready), 64'd1);
      checkOutput("rst_rd_ready", 64'(bus.rd_ready), 64'd1);
      checkOutput("rst_rd_data_valid", 64'(bus.rd_data_valid), 64'd0);
      checkOutput("rst_rd_data", 64'(bus.rd_data), 64'd0);
      checkOutput("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
      checkOutput("rst_mem_wen", 64'(bus.mem_wen), 64'd0);
      checkOutput("rst_mem_raddr", 64'(bus.mem_raddr), 64'd0);
      checkOutput("rst_mem_waddr", 64'(bus.mem_waddr), 64'd0);
      checkOutput("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      $display("[TB] single update, bin 5 from 7");
      preload(8'd5, 32'd7);
      applyStimulus(1, 8'd5, 0, 0, 0);
      #1;
      checkOutput("upd5_ready", 64'(bus.upd_ready), 64'd1);
      checkOutput("upd5_raddr", 64'(bus.mem_raddr), 64'd5);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checkOutput("upd5_wen", 64'(bus.mem_wen), 64'd1);
      checkOutput("upd5_waddr", 64'(bus.mem_waddr), 64'd5);
      checkOutput("upd5_wdata", 64'(bus.mem_wdata), 64'd8);
      tick();

      $display("[TB] four back-to-back updates, bin 9 from 0");
      preload(8'd9, 32'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus((i < 4), 8'd9, 0, 0, 0);
         #1;
         if (i < 4) checkOutput("b2b_ready", 64'(bus.upd_ready), 64'd1);
         if (i > 0) begin
            checkOutput("b2b_wen", 64'(bus.mem_wen), 64'd1);
            checkOutput("b2b_wdata", 64'(bus.mem_wdata), 64'(i));
         end
         tick();
      end

      $display("[TB] update then read of bin 3 from 10");
      preload(8'd3, 32'd10);
      applyStimulus(1, 8'd3, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 1, 8'd3, 0);
      #1;
      checkOutput("raw_rd_ready", 64'(bus.rd_ready), 64'd1);
      checkOutput("raw_upd_wdata", 64'(bus.mem_wdata), 64'd11);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checkOutput("raw_rd_valid", 64'(bus.rd_data_valid), 64'd1);
      checkOutput("raw_rd_data", 64'(bus.rd_data), 64'd11);
      checkOutput("raw_rd_no_wen", 64'(bus.mem_wen), 64'd0);
      tick();

      $display("[TB] simultaneous read/update alternation after reset");
      preload(8'd20, 32'd100);
      preload(8'd21, 32'd200);
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 8'd21, 1, 8'd20, 0);
         #1;
         checkOutput("rr_rd_ready", 64'(bus.rd_ready), 64'((i % 2) == 0));
         checkOutput("rr_upd_ready", 64'(bus.upd_ready), 64'((i % 2) == 1));
         checkOutput("rr_raddr", 64'(bus.mem_raddr), ((i % 2) == 0) ? 64'd20 : 64'd21);
         if (i == 1 || i == 3) checkOutput("rr_rd_data", 64'(bus.rd_data), 64'd100);
         if (i == 2) checkOutput("rr_wdata_1", 64'(bus.mem_wdata), 64'd201);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checkOutput("rr_wdata_2", 64'(bus.mem_wdata), 64'd202);
      tick();

      $display("[TB] increment at maximum value");
      preload(8'd7, 32'hFFFF_FFFF);
      applyStimulus(1, 8'd7, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      #1;
`ifdef HIST_BIN_SATURATE_EN
      satExp = 32'hFFFF_FFFF;
`else
      satExp = 32'h0000_0000;
`endif
      checkOutput("max_wdata", 64'(bus.mem_wdata), 64'(satExp));
      tick();

      $display("[TB] bulk clear");
      runClear();
      tick();
      applyStimulus(0, 0, 1, 8'd5, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checkOutput("post_clr_rd_valid", 64'(bus.rd_data_valid), 64'd1);
      checkOutput("post_clr_rd_data", 64'(bus.rd_data), 64'd0);
      tick();

      $display("[TB] reset in the middle of a clear");
      applyStimulus(0, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      repeat (50) tick();
      #1;
      checkOutput("mid_clr_busy_before", 64'(bus.clr_busy), 64'd1);
      rst_ni = 1'b0;
      #1;
      checkOutput("mid_rst_clr_busy", 64'(bus.clr_busy), 64'd0);
      checkOutput("mid_rst_rd_ready", 64'(bus.rd_ready), 64'd1);
      checkOutput("mid_rst_upd_ready", 64'(bus.upd_ready), 64'd1);
      checkOutput("mid_rst_mem_wen", 64'(bus.mem_wen), 64'd0);
      tick();
      rst_ni = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
